stim_train_sequencer: RTL and testbench
=======================================

STIM_TRAIN_SEQUENCER -- requirements
Module: stim_train_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all duration/count inputs.
REQ-002 SHALL have parameter MAG_W, default 8, width of pulse magnitude.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle timebase strobe; all durations are counted in ticks.
- finite_start  in  1  pulse; starts a finite run.
- infinite_start  in  1  pulse; starts an infinite run.
- stop  in  1  pulse; requests a graceful end.
- pulse_length, inter_pulse_delay, inter_bipulse_delay, inter_train_delay, charge_recovery_time  in  CNT_W each  durations in ticks.
- bipulses_per_train, train_count  in  CNT_W each  counts.
- pulse_magnitude  in  MAG_W  amplitude code.
- rising_edge_first  in  1  1 = positive phase first.
- phase_pos  out  1  positive phase active.
- phase_neg  out  1  negative phase active.
- magnitude  out  MAG_W  latched magnitude during a phase, else 0.
- recovery  out  1  charge-recovery window active.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on completion.
- cfg_err  out  1  one-cycle pulse on a rejected finite start.
- train_idx, bipulse_idx  out  CNT_W each  zero-based position.

Function
REQ-004 SHALL implement states IDLE, ARM, PH1, IPD, PH2, IBD, ITD, RECOV.
REQ-005 SHALL latch all configuration inputs and the mode (finite/infinite) on an accepted start; inputs SHALL be ignored afterwards until IDLE.
REQ-006 SHALL accept a start only in IDLE; a start while busy SHALL be ignored.
REQ-007 SHALL give finite_start priority when both starts assert in the same cycle.
REQ-008 SHALL reject finite_start when bipulses_per_train==0 or train_count==0: pulse cfg_err, remain in IDLE.
REQ-009 SHALL reject infinite_start when bipulses_per_train==0: pulse cfg_err, remain in IDLE.
REQ-010 SHALL go IDLE->ARM on an accepted start; ARM->PH1 on the next tick.
REQ-011 SHALL hold each timed state for exactly max(D,1) ticks, where D is its latched duration:
- PH1, PH2: pulse_length
- IPD: inter_pulse_delay
- IBD: inter_bipulse_delay
- ITD: inter_train_delay
- RECOV: charge_recovery_time
The transition SHALL occur on the clk edge of the terminal tick.
REQ-012 SHALL sequence PH1->IPD->PH2.
REQ-013 SHALL leave PH2 as follows:
- if bipulse_idx < bipulses_per_train-1: go to IBD (bipulse_idx+1), then PH1.
- else if more trains remain, or mode is infinite: go to ITD (train_idx+1, bipulse_idx=0), then PH1.
- else: go to RECOV.
REQ-014 SHALL, after RECOV ends, go to IDLE and pulse done in the same cycle.
REQ-015 SHALL, on stop in any state from ARM through ITD, set a sticky stop flag; at the next exit from PH2, or immediately if in IBD, ITD or ARM, go to RECOV. A stop in RECOV or IDLE SHALL have no effect.
REQ-016 SHALL wrap train_idx to 0 at 2^CNT_W in infinite mode with no other effect.
REQ-017 SHALL drive phase outputs in PH1 and PH2 only:
- rising_edge_first=1: phase_pos in PH1, phase_neg in PH2.
- rising_edge_first=0: the reverse.
REQ-018 SHALL never assert phase_pos and phase_neg together.
REQ-019 SHALL drive magnitude = latched magnitude whenever phase_pos or phase_neg is set, else 0.
REQ-020 SHALL drive recovery=1 exactly in RECOV.
REQ-021 SHALL register all outputs; they SHALL reflect the current state with no combinational path from inputs.
REQ-022 SHALL ignore ticks while in IDLE.

Reset
REQ-023 SHALL, on rst, asynchronously force:
- state IDLE
- all outputs 0
- counters, indices, stop flag and latched config 0
REQ-024 SHALL, on rst asserted mid-run, drop phase_pos/phase_neg/magnitude immediately and SHALL NOT pulse done.

Verification
REQ-025 SHALL pass: finite run with pulse_length=1, ipd=1, ibd=1, itd=12, bipulses=4, trains=4, recovery=8, magnitude=100, rising_edge_first=1 -> 16 phase_pos and 16 phase_neg tick-windows, magnitude=100 during each, done exactly 105 ticks after start (1 ARM + 96 run + 8 RECOV).
REQ-026 SHALL pass: same config with rising_edge_first=0 -> phase_neg precedes phase_pos in every bipulse; total length unchanged.
REQ-027 SHALL pass: infinite_start, stop during ITD of train 2 -> immediate RECOV of 8 ticks, done, train_idx=2 at stop.
REQ-028 SHALL pass: stop during PH1 of a bipulse -> that bipulse completes PH2, then RECOV; bipulse count balanced (pos count == neg count).
REQ-029 SHALL pass: finite_start with train_count=0 -> cfg_err pulse, busy stays 0; finite_start+infinite_start in the same cycle -> finite run.
REQ-030 SHALL pass: rst asserted mid-PH2 -> all outputs 0 asynchronously before the next clk edge, no done; a fresh start after reset release runs normally.

Source files
------------

// File: rtl/stim_train_sequencer.sv
// Biphasic stimulation train sequencer: plays bipulses grouped into trains on a
// tick timebase, then a charge-recovery window, in finite or infinite mode.
module stim_train_sequencer #(
  parameter int CNT_W = 16,
  parameter int MAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             finite_start,
  input  logic             infinite_start,
  input  logic             stop,
  input  logic [CNT_W-1:0] pulse_length,
  input  logic [CNT_W-1:0] inter_pulse_delay,
  input  logic [CNT_W-1:0] inter_bipulse_delay,
  input  logic [CNT_W-1:0] inter_train_delay,
  input  logic [CNT_W-1:0] charge_recovery_time,
  input  logic [CNT_W-1:0] bipulses_per_train,
  input  logic [CNT_W-1:0] train_count,
  input  logic [MAG_W-1:0] pulse_magnitude,
  input  logic             rising_edge_first,
  output logic             phase_pos,
  output logic             phase_neg,
  output logic [MAG_W-1:0] magnitude,
  output logic             recovery,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] train_idx,
  output logic [CNT_W-1:0] bipulse_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_PH1, S_IPD, S_PH2, S_IBD, S_ITD, S_RECOV
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_trainIdx;
  logic [CNT_W-1:0] r_bipIdx;
  logic             r_stopFlag;
  logic [CNT_W-1:0] r_pulseLen;
  logic [CNT_W-1:0] r_ipd;
  logic [CNT_W-1:0] r_ibd;
  logic [CNT_W-1:0] r_itd;
  logic [CNT_W-1:0] r_recTime;
  logic [CNT_W-1:0] r_bpt;
  logic [CNT_W-1:0] r_trains;
  logic [MAG_W-1:0] r_mag;
  logic             r_risingFirst;
  logic             r_infinite;

  state_t           w_stateNext;
  logic [CNT_W-1:0] w_cntNext;
  logic [CNT_W-1:0] w_trainNext;
  logic [CNT_W-1:0] w_bipNext;
  logic             w_stopNext;
  logic             w_load;
  logic             w_loadInfinite;
  logic             w_cfgErr;
  logic             w_done;
  logic [CNT_W-1:0] w_dur;
  logic [CNT_W-1:0] w_lastCnt;
  logic             w_termTick;
  logic             w_stopReq;
  logic             w_moreBip;
  logic             w_moreTrain;
  logic             w_posNext;
  logic             w_negNext;

  // Duration of the current timed state; zero is treated as a single tick.
  always_comb begin
    w_dur = '0;
    case (r_state)
      S_PH1, S_PH2: w_dur = r_pulseLen;
      S_IPD:        w_dur = r_ipd;
      S_IBD:        w_dur = r_ibd;
      S_ITD:        w_dur = r_itd;
      S_RECOV:      w_dur = r_recTime;
      default:      w_dur = '0;
    endcase
    w_lastCnt   = (w_dur == '0) ? '0 : w_dur - 1'b1;
    w_termTick  = tick && (r_cnt >= w_lastCnt);
    w_stopReq   = r_stopFlag || stop;
    w_moreBip   = r_bipIdx < (r_bpt - 1'b1);
    w_moreTrain = r_infinite || (r_trainIdx < (r_trains - 1'b1));
  end

  // Next-state logic; the tick counter restarts on every state change.
  always_comb begin
    w_stateNext    = r_state;
    w_trainNext    = r_trainIdx;
    w_bipNext      = r_bipIdx;
    w_stopNext     = r_stopFlag;
    w_load         = 1'b0;
    w_loadInfinite = 1'b0;
    w_cfgErr       = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (finite_start) begin
          if (bipulses_per_train == '0 || train_count == '0) begin
            w_cfgErr = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_stateNext = S_ARM;
          end
        end else if (infinite_start) begin
          if (bipulses_per_train == '0) begin
            w_cfgErr = 1'b1;
          end else begin
            w_load         = 1'b1;
            w_loadInfinite = 1'b1;
            w_stateNext    = S_ARM;
          end
        end
        if (w_load) begin
          w_trainNext = '0;
          w_bipNext   = '0;
          w_stopNext  = 1'b0;
        end
      end
      S_ARM: begin
        if (w_stopReq) begin
          w_stopNext  = 1'b1;
          w_stateNext = S_RECOV;
        end else if (tick) begin
          w_stateNext = S_PH1;
        end
      end
      S_PH1, S_IPD: begin
        if (stop) w_stopNext = 1'b1;
        if (w_termTick) w_stateNext = (r_state == S_PH1) ? S_IPD : S_PH2;
      end
      S_PH2: begin
        if (stop) w_stopNext = 1'b1;
        if (w_termTick) begin
          if (w_stopReq) begin
            w_stateNext = S_RECOV;
          end else if (w_moreBip) begin
            w_stateNext = S_IBD;
            w_bipNext   = r_bipIdx + 1'b1;
          end else if (w_moreTrain) begin
            w_stateNext = S_ITD;
            w_trainNext = r_trainIdx + 1'b1;
            w_bipNext   = '0;
          end else begin
            w_stateNext = S_RECOV;
          end
        end
      end
      S_IBD, S_ITD: begin
        if (w_stopReq) begin
          w_stopNext  = 1'b1;
          w_stateNext = S_RECOV;
        end else if (w_termTick) begin
          w_stateNext = S_PH1;
        end
      end
      S_RECOV: begin
        if (w_termTick) begin
          w_stateNext = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase

    if (w_stateNext != r_state || r_state == S_IDLE) w_cntNext = '0;
    else if (tick) w_cntNext = r_cnt + 1'b1;
    else w_cntNext = r_cnt;

    w_posNext = (w_stateNext == S_PH1 && r_risingFirst) ||
                (w_stateNext == S_PH2 && !r_risingFirst);
    w_negNext = (w_stateNext == S_PH1 && !r_risingFirst) ||
                (w_stateNext == S_PH2 && r_risingFirst);
  end

  // Outputs are registered from the next state so they track the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_trainIdx    <= '0;
      r_bipIdx      <= '0;
      r_stopFlag    <= 1'b0;
      r_pulseLen    <= '0;
      r_ipd         <= '0;
      r_ibd         <= '0;
      r_itd         <= '0;
      r_recTime     <= '0;
      r_bpt         <= '0;
      r_trains      <= '0;
      r_mag         <= '0;
      r_risingFirst <= 1'b0;
      r_infinite    <= 1'b0;
      phase_pos     <= 1'b0;
      phase_neg     <= 1'b0;
      magnitude     <= '0;
      recovery      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      train_idx     <= '0;
      bipulse_idx   <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_trainIdx <= w_trainNext;
      r_bipIdx   <= w_bipNext;
      r_stopFlag <= w_stopNext;
      if (w_load) begin
        r_pulseLen    <= pulse_length;
        r_ipd         <= inter_pulse_delay;
        r_ibd         <= inter_bipulse_delay;
        r_itd         <= inter_train_delay;
        r_recTime     <= charge_recovery_time;
        r_bpt         <= bipulses_per_train;
        r_trains      <= train_count;
        r_mag         <= pulse_magnitude;
        r_risingFirst <= rising_edge_first;
        r_infinite    <= w_loadInfinite;
      end
      phase_pos   <= w_posNext;
      phase_neg   <= w_negNext;
      magnitude   <= (w_posNext || w_negNext) ? r_mag : '0;
      recovery    <= (w_stateNext == S_RECOV);
      busy        <= (w_stateNext != S_IDLE);
      done        <= w_done;
      cfg_err     <= w_cfgErr;
      train_idx   <= w_trainNext;
      bipulse_idx <= w_bipNext;
    end
  end

endmodule

// File: tb/tb_stim_train_sequencer.sv
// Scoreboard bench for stim_train_sequencer: directed runs queue their expected
// run summary, and a negedge monitor measures each run and compares on done/cfg_err.
module tb_stim_train_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b1;
  logic        finite_start = 1'b0;
  logic        infinite_start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] pulse_length = '0;
  logic [15:0] inter_pulse_delay = '0;
  logic [15:0] inter_bipulse_delay = '0;
  logic [15:0] inter_train_delay = '0;
  logic [15:0] charge_recovery_time = '0;
  logic [15:0] bipulses_per_train = '0;
  logic [15:0] train_count = '0;
  logic [7:0]  pulse_magnitude = '0;
  logic        rising_edge_first = 1'b0;
  logic        phase_pos, phase_neg, recovery, busy, done, cfg_err;
  logic [7:0]  magnitude;
  logic [15:0] train_idx, bipulse_idx;

  typedef struct {
    int kind;
    int ticks;
    int pos;
    int neg;
    int firstPos;
    int trainIdx;
    int recTicks;
    int mag;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  bit   sparseTick = 1'b0;

  stim_train_sequencer dut (
    .clk(clk), .rst(rst), .tick(tick),
    .finite_start(finite_start), .infinite_start(infinite_start), .stop(stop),
    .pulse_length(pulse_length), .inter_pulse_delay(inter_pulse_delay),
    .inter_bipulse_delay(inter_bipulse_delay), .inter_train_delay(inter_train_delay),
    .charge_recovery_time(charge_recovery_time), .bipulses_per_train(bipulses_per_train),
    .train_count(train_count), .pulse_magnitude(pulse_magnitude),
    .rising_edge_first(rising_edge_first),
    .phase_pos(phase_pos), .phase_neg(phase_neg), .magnitude(magnitude),
    .recovery(recovery), .busy(busy), .done(done), .cfg_err(cfg_err),
    .train_idx(train_idx), .bipulse_idx(bipulse_idx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Tick generator: every cycle, or one cycle in three for the sparse-tick run.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      tick = sparseTick ? (ph % 3 == 0) : 1'b1;
      ph++;
    end
  end

  // Monitor: measures the current run and scores it against the queue head.
  initial begin
    int runTicks = 0, recTicks = 0, posCnt = 0, negCnt = 0, lastPh = 0;
    int firstPos = 0, orderErr = 0, magErr = 0, overlap = 0;
    bit prevPos = 0, prevNeg = 0, prevBusy = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevPos = 0; prevNeg = 0; prevBusy = 0;
        continue;
      end
      if (busy && !prevBusy) begin
        runTicks = 0; recTicks = 0; posCnt = 0; negCnt = 0; lastPh = 0;
        firstPos = 0; orderErr = 0; magErr = 0; overlap = 0;
      end
      if (busy && tick) runTicks++;
      if (recovery && tick) recTicks++;
      if (phase_pos && phase_neg) overlap++;
      if (phase_pos && !prevPos) begin
        if (lastPh == 0) firstPos = 1;
        else if (lastPh == 1) orderErr++;
        lastPh = 1;
        posCnt++;
      end
      if (phase_neg && !prevNeg) begin
        if (lastPh == 2) orderErr++;
        lastPh = 2;
        negCnt++;
      end
      if (phase_pos || phase_neg) begin
        if (expQ.size() > 0 && int'(magnitude) != expQ[0].mag) magErr++;
      end else if (magnitude != 8'd0) begin
        magErr++;
      end
      if (done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("done_kind", 0, e.kind);
          checkOutput("run_ticks", runTicks, e.ticks);
          checkOutput("pos_windows", posCnt, e.pos);
          checkOutput("neg_windows", negCnt, e.neg);
          checkOutput("pos_first", firstPos, e.firstPos);
          checkOutput("phase_order_errs", orderErr, 0);
          checkOutput("phase_overlap", overlap, 0);
          checkOutput("magnitude_errs", magErr, 0);
          checkOutput("train_idx_at_done", int'(train_idx), e.trainIdx);
          checkOutput("recovery_ticks", recTicks, e.recTicks);
        end
      end
      if (cfg_err) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_cfg_err", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("cfg_err_kind", 1, e.kind);
          checkOutput("cfg_err_busy", busy, 0);
        end
      end
      prevPos = phase_pos; prevNeg = phase_neg; prevBusy = busy;
    end
  end

  task automatic setCfg(input int pl, input int ipd, input int ibd, input int itd,
                        input int rec, input int bp, input int tc, input int mag,
                        input bit rfirst);
    pulse_length         = 16'(pl);
    inter_pulse_delay    = 16'(ipd);
    inter_bipulse_delay  = 16'(ibd);
    inter_train_delay    = 16'(itd);
    charge_recovery_time = 16'(rec);
    bipulses_per_train   = 16'(bp);
    train_count          = 16'(tc);
    pulse_magnitude      = 8'(mag);
    rising_edge_first    = rfirst;
  endtask

  task automatic pushExp(input int kind, input int ticks, input int pos, input int neg,
                         input int firstPos, input int trainIdx, input int recTicks,
                         input int mag);
    exp_t e;
    e.kind = kind; e.ticks = ticks; e.pos = pos; e.neg = neg;
    e.firstPos = firstPos; e.trainIdx = trainIdx; e.recTicks = recTicks; e.mag = mag;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit fin, input bit inf);
    @(posedge clk);
    #1;
    finite_start = fin;
    infinite_start = inf;
    @(posedge clk);
    #1;
    finite_start = 1'b0;
    infinite_start = 1'b0;
  endtask

  task automatic waitIdle(input string nm);
    int n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput({nm, "_timeout"}, 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulseStop();
    @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    checkOutput("rst_phase_pos", phase_pos, 0);
    checkOutput("rst_phase_neg", phase_neg, 0);
    checkOutput("rst_magnitude", magnitude, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done_cfg_rec", {done, cfg_err, recovery}, 0);
    checkOutput("rst_indices", {train_idx, bipulse_idx}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Stop while idle has no effect.
    pulseStop();

    // Reference finite run, positive phase first: 1 ARM + 96 run + 8 RECOV.
    setCfg(1, 1, 1, 12, 8, 4, 4, 100, 1'b1);
    pushExp(0, 105, 16, 16, 1, 3, 8, 100);
    applyStimulus(1'b1, 1'b0);
    waitIdle("finite_pos_first");

    // Same run, negative phase first.
    setCfg(1, 1, 1, 12, 8, 4, 4, 100, 1'b0);
    pushExp(0, 105, 16, 16, 0, 3, 8, 100);
    applyStimulus(1'b1, 1'b0);
    waitIdle("finite_neg_first");

    // Infinite run stopped two ticks into the ITD that opens train 2.
    setCfg(1, 1, 1, 12, 8, 4, 0, 55, 1'b1);
    pushExp(0, 53, 8, 8, 1, 2, 8, 55);
    applyStimulus(1'b0, 1'b1);
    n = 0;
    while (train_idx != 16'd2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (train_idx != 16'd2) checkOutput("wait_train2_timeout", 1, 0);
    pulseStop();
    waitIdle("infinite_stop_itd");

    // Stop during PH1 of bipulse 1: that bipulse finishes, then recovery.
    setCfg(3, 2, 2, 4, 5, 3, 2, 200, 1'b1);
    pushExp(0, 24, 2, 2, 1, 0, 5, 200);
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (!(phase_pos && bipulse_idx == 16'd1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!(phase_pos && bipulse_idx == 16'd1)) checkOutput("wait_ph1_timeout", 1, 0);
    pulseStop();
    waitIdle("stop_in_ph1");

    // Rejected starts: finite with zero trains, infinite with zero bipulses.
    setCfg(1, 1, 1, 1, 1, 2, 0, 9, 1'b1);
    pushExp(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reject_finite_busy", busy, 0);
    setCfg(1, 1, 1, 1, 1, 0, 3, 9, 1'b1);
    pushExp(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("reject_infinite_busy", busy, 0);

    // Both starts together run finite; a mid-run start with new config is ignored.
    setCfg(2, 1, 1, 3, 2, 2, 2, 7, 1'b1);
    pushExp(0, 28, 4, 4, 1, 1, 2, 7);
    applyStimulus(1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    pulse_length = 16'd9;
    pulse_magnitude = 8'd99;
    applyStimulus(1'b1, 1'b0);
    waitIdle("both_starts");

    // Zero durations count as one tick, with a sparse timebase.
    sparseTick = 1'b1;
    setCfg(0, 0, 2, 0, 0, 2, 1, 33, 1'b0);
    pushExp(0, 10, 2, 2, 0, 0, 1, 33);
    applyStimulus(1'b1, 1'b0);
    waitIdle("zero_durations");
    sparseTick = 1'b0;
    repeat (2) @(posedge clk);

    // Reset mid-PH2 clears outputs before the next edge and yields no done.
    setCfg(4, 1, 1, 1, 3, 2, 1, 77, 1'b1);
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (!phase_neg && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_ph2", phase_neg, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_phase_neg", phase_neg, 0);
    checkOutput("async_rst_magnitude", magnitude, 0);
    checkOutput("async_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("post_rst_idle", busy, 0);

    // Fresh run after reset release.
    setCfg(3, 2, 2, 4, 5, 3, 2, 150, 1'b1);
    pushExp(0, 66, 6, 6, 1, 1, 5, 150);
    applyStimulus(1'b1, 1'b0);
    waitIdle("after_reset");

    checkOutput("pending_expectations", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
